// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM demultiplexer.
// Define TDM_DEMUX_PARITY_EN to append an even-parity bit after the last slot.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned CH_DEF = 4;
  localparam int unsigned W_DEF  = 8;

`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Serial bits per frame, including the parity bit when present.
  function automatic int unsigned frame_len(input int unsigned ch, input int unsigned w);
    return ch * w + (PARITY_EN ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit/slot position tracker for one TDM frame; counters hold the position of
// the next bit to be sampled. i_clear restarts at frame start, i_step advances.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int unsigned CH = CH_DEF,
  parameter int unsigned W  = W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_step,
  output logic o_frame_start_c,
  output logic o_frame_end_c,
  output logic o_parity_slot_c
);

  localparam int unsigned BW = $clog2(W);
  localparam int unsigned SW = $clog2(CH);

  logic [BW-1:0] r_bit_cnt;
  logic [SW-1:0] r_slot_cnt;
  logic          r_par_slot;
  logic [BW-1:0] w_bit_cnt;
  logic [SW-1:0] w_slot_cnt;
  logic          w_par_slot;

  // Clear takes effect before the step, so clear+step lands on bit 1 of slot 0.
  always_comb begin
    w_bit_cnt  = i_clear ? '0 : r_bit_cnt;
    w_slot_cnt = i_clear ? '0 : r_slot_cnt;
    w_par_slot = i_clear ? 1'b0 : r_par_slot;
    if (i_step) begin
      if (w_par_slot) begin
        w_par_slot = 1'b0;
      end else if (w_bit_cnt == BW'(W - 1)) begin
        w_bit_cnt = '0;
        if (w_slot_cnt == SW'(CH - 1)) begin
          w_slot_cnt = '0;
          w_par_slot = PARITY_EN;
        end else begin
          w_slot_cnt = w_slot_cnt + SW'(1);
        end
      end else begin
        w_bit_cnt = w_bit_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_slot_cnt <= '0;
      r_par_slot <= 1'b0;
    end else begin
      r_bit_cnt  <= w_bit_cnt;
      r_slot_cnt <= w_slot_cnt;
      r_par_slot <= w_par_slot;
    end
  end

  assign o_frame_start_c = !r_par_slot && (r_bit_cnt == '0) && (r_slot_cnt == '0);
  assign o_frame_end_c   = !r_par_slot && (r_bit_cnt == BW'(W - 1)) && (r_slot_cnt == SW'(CH - 1));
  assign o_parity_slot_c = r_par_slot;

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: locks to fsync and deserializes CH slots of W bits.
// Optional trailing even-parity bit enabled by TDM_DEMUX_PARITY_EN.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned CH = CH_DEF,
  parameter int unsigned W  = W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          din,
  input  logic          fsync,
  output logic [CH*W-1:0] dout,
  output logic          frame_valid,
  output logic          locked,
  output logic          err
);

  localparam int unsigned DW = CH * W;

  state_t        r_state;
  logic [DW-1:0] r_shadow;
  logic [DW-1:0] r_dout;
  logic          r_frame_valid;
  logic          r_err;
  logic          r_locked;
  logic          r_par_acc;

  state_t        w_state_nxt;
  logic [DW-1:0] w_shadow;
  logic [DW-1:0] w_shifted;
  logic [DW-1:0] w_dout;
  logic          w_frame_valid;
  logic          w_err;
  logic          w_locked;
  logic          w_par_acc;
  logic          w_clear;
  logic          w_step;
  logic          w_frame_start;
  logic          w_frame_end;
  logic          w_parity_slot;

  tdm_slot_counter #(.CH(CH), .W(W)) u_slot_counter (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clear         (w_clear),
    .i_step          (w_step),
    .o_frame_start_c (w_frame_start),
    .o_frame_end_c   (w_frame_end),
    .o_parity_slot_c (w_parity_slot)
  );

  // Slot 0 arrives first so it ends up in the top of the shift register.
  function automatic logic [DW-1:0] remap(input logic [DW-1:0] s);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < int'(CH); k++) begin
      v[k*W +: W] = s[(int'(CH) - 1 - k)*W +: W];
    end
    return v;
  endfunction

  // Next-state and datapath decisions, evaluated only on en edges.
  always_comb begin
    w_state_nxt   = r_state;
    w_shadow      = r_shadow;
    w_dout        = r_dout;
    w_frame_valid = 1'b0;
    w_err         = 1'b0;
    w_locked      = r_locked;
    w_par_acc     = r_par_acc;
    w_clear       = 1'b0;
    w_step        = 1'b0;
    w_shifted     = {r_shadow[DW-2:0], din};
    if (en) begin
      unique case (r_state)
        HUNT: begin
          if (fsync) begin
            w_shadow    = w_shifted;
            w_par_acc   = din;
            w_clear     = 1'b1;
            w_step      = 1'b1;
            w_state_nxt = RUN;
            w_locked    = 1'b1;
          end
        end
        RUN: begin
          if (w_frame_start) begin
            if (fsync) begin
              w_shadow  = w_shifted;
              w_par_acc = din;
              w_clear   = 1'b1;
              w_step    = 1'b1;
            end else begin
              w_err       = 1'b1;
              w_locked    = 1'b0;
              w_state_nxt = HUNT;
              w_clear     = 1'b1;
            end
          end else if (fsync) begin
            // Misplaced marker: abandon the partial frame and restart on this bit.
            w_err     = 1'b1;
            w_shadow  = w_shifted;
            w_par_acc = din;
            w_clear   = 1'b1;
            w_step    = 1'b1;
          end else if (w_parity_slot) begin
            w_step = 1'b1;
            if (r_par_acc ^ din) begin
              w_err = 1'b1;
            end else begin
              w_dout        = remap(r_shadow);
              w_frame_valid = 1'b1;
            end
          end else begin
            w_shadow  = w_shifted;
            w_par_acc = r_par_acc ^ din;
            w_step    = 1'b1;
            if (w_frame_end && !PARITY_EN) begin
              w_dout        = remap(w_shifted);
              w_frame_valid = 1'b1;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= HUNT;
      r_shadow      <= '0;
      r_dout        <= '0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
      r_locked      <= 1'b0;
      r_par_acc     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shadow      <= w_shadow;
      r_dout        <= w_dout;
      r_frame_valid <= w_frame_valid;
      r_err         <= w_err;
      r_locked      <= w_locked;
      r_par_acc     <= w_par_acc;
    end
  end

  assign dout        = r_dout;
  assign frame_valid = r_frame_valid;
  assign locked      = r_locked;
  assign err         = r_err;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios plus randomized frames
// compared every cycle against a bit-queue reference model.
module tb_tdm_demux;
  import tdm_pkg::*;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned DW = CH * W;
  localparam int unsigned NB = DW;
  localparam int unsigned FL = frame_len(CH, W);

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          din;
  logic          fsync;
  logic [DW-1:0] dout;
  logic          frame_valid;
  logic          locked;
  logic          err;

  int n_assert;
  int n_fail;
  int n_fv_seen;
  int n_err_seen;

  bit            m_q[$];
  bit            m_locked;
  logic [DW-1:0] m_dout;
  bit            m_fv;
  bit            m_err;

  tdm_demux #(.CH(CH), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .din         (din),
    .fsync       (fsync),
    .dout        (dout),
    .frame_valid (frame_valid),
    .locked      (locked),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word k of the frame is built from bits k*W .. k*W+W-1 of the stream, MSB first.
  function automatic logic [DW-1:0] pack_q();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NB); i++) begin
      v[(i / int'(W)) * int'(W) + (int'(W) - 1 - (i % int'(W)))] = m_q[i];
    end
    return v;
  endfunction

  // Reference behaviour for one clock edge, from the frame rules.
  task automatic model_edge();
    bit p;
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (!rst_n) begin
      m_locked = 1'b0;
      m_q.delete();
      m_dout = '0;
    end else if (en) begin
      if (!m_locked) begin
        if (fsync) begin
          m_locked = 1'b1;
          m_q = {din};
        end
      end else if (m_q.size() == 0) begin
        if (fsync) m_q = {din};
        else begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end
      end else if (fsync) begin
        m_err = 1'b1;
        m_q   = {din};
      end else if (PARITY_EN && m_q.size() == int'(NB)) begin
        p = din;
        foreach (m_q[i]) p ^= m_q[i];
        if (p) m_err = 1'b1;
        else begin
          m_dout = pack_q();
          m_fv   = 1'b1;
        end
        m_q.delete();
      end else begin
        m_q.push_back(din);
        if (!PARITY_EN && m_q.size() == int'(NB)) begin
          m_dout = pack_q();
          m_fv   = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic bit_cyc(input logic e, input logic d, input logic f);
    @(negedge clk);
    en    = e;
    din   = d;
    fsync = f;
    @(posedge clk);
    model_edge();
    #1;
    chk("dout", dout, m_dout);
    chk("frame_valid", DW'(frame_valid), DW'(m_fv));
    chk("locked", DW'(locked), DW'(m_locked));
    chk("err", DW'(err), DW'(m_err));
    if (frame_valid === 1'b1) n_fv_seen++;
    if (err === 1'b1) n_err_seen++;
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input int nbits, input bit sync0,
                            input bit gaps, input bit bad_par);
    logic p;
    logic b;
    p = (^data) ^ bad_par;
    for (int i = 0; i < nbits; i++) begin
      if (i < int'(NB)) b = data[(i / int'(W)) * int'(W) + (int'(W) - 1 - (i % int'(W)))];
      else b = p;
      bit_cyc(1'b1, b, (i == 0) && sync0);
      if (gaps) bit_cyc(1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic clr_seen();
    n_fv_seen  = 0;
    n_err_seen = 0;
  endtask

  initial begin
    logic [DW-1:0] rnd;
    n_assert = 0;
    n_fail   = 0;
    clr_seen();
    m_locked = 1'b0;
    m_dout   = '0;
    m_fv     = 1'b0;
    m_err    = 1'b0;
    rst_n = 1'b0;
    en    = 1'b0;
    din   = 1'b0;
    fsync = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 5; i++) bit_cyc(1'($urandom), 1'($urandom), 1'($urandom));
    chk("rst_dout", dout, '0);
    chk("rst_fv", DW'(frame_valid), '0);
    chk("rst_locked", DW'(locked), '0);
    chk("rst_err", DW'(err), '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) bit_cyc(1'b1, 1'($urandom), 1'b0);
    chk("hunt_idle_locked", DW'(locked), '0);

    // Lock and decode
    clr_seen();
    send_frame(32'h01FF3CA5, FL, 1'b1, 1'b0, 1'b0);
    chk("decode_dout", dout, 32'h01FF3CA5);
    chk("decode_fv", DW'(frame_valid), DW'(1));
    chk("decode_locked", DW'(locked), DW'(1));
    chk("decode_fv_count", DW'(n_fv_seen), DW'(1));

    // Missing sync at frame start
    bit_cyc(1'b1, 1'($urandom), 1'b0);
    chk("nosync_err", DW'(err), DW'(1));
    chk("nosync_locked", DW'(locked), '0);
    chk("nosync_dout", dout, 32'h01FF3CA5);
    for (int i = 0; i < 40; i++) bit_cyc(1'b1, 1'($urandom), 1'b0);
    chk("nosync_stays_hunt", DW'(locked), '0);
    send_frame(32'hDEADBEEF, FL, 1'b1, 1'b0, 1'b0);
    chk("relock_dout", dout, 32'hDEADBEEF);

    // Early sync at bit 12
    clr_seen();
    send_frame(32'h0BADF00D, 12, 1'b1, 1'b0, 1'b0);
    send_frame(32'h5A5A1234, FL, 1'b1, 1'b0, 1'b0);
    chk("early_err_count", DW'(n_err_seen), DW'(1));
    chk("early_fv_count", DW'(n_fv_seen), DW'(1));
    chk("early_dout", dout, 32'h5A5A1234);

    // en toggling every cycle
    clr_seen();
    send_frame(32'hC0FFEE42, FL, 1'b1, 1'b1, 1'b0);
    chk("gap_dout", dout, 32'hC0FFEE42);
    chk("gap_fv_count", DW'(n_fv_seen), DW'(1));
    chk("gap_err_count", DW'(n_err_seen), '0);

`ifdef TDM_DEMUX_PARITY_EN
    clr_seen();
    send_frame(32'h13579BDF, FL, 1'b1, 1'b0, 1'b1);
    chk("badpar_err_count", DW'(n_err_seen), DW'(1));
    chk("badpar_fv_count", DW'(n_fv_seen), '0);
    chk("badpar_dout", dout, 32'hC0FFEE42);
    chk("badpar_locked", DW'(locked), DW'(1));
    send_frame(32'h2468ACE0, FL, 1'b1, 1'b0, 1'b0);
    chk("after_badpar_dout", dout, 32'h2468ACE0);
`endif

    // Randomized frames with gaps and occasional sync faults
    for (int fr = 0; fr < 25; fr++) begin
      rnd = DW'($urandom);
      for (int i = 0; i < int'(FL); i++) begin
        logic b;
        logic f;
        if (i < int'(NB)) b = rnd[(i / int'(W)) * int'(W) + (int'(W) - 1 - (i % int'(W)))];
        else b = (^rnd) ^ ($urandom_range(0, 9) == 0);
        f = (i == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 59) == 0);
        for (int g = 0; g < int'($urandom_range(0, 2)); g++)
          bit_cyc(1'b0, 1'($urandom), 1'($urandom));
        bit_cyc(1'b1, b, f);
      end
    end

    // Reset mid-frame
    send_frame(32'h89ABCDEF, FL, 1'b1, 1'b0, 1'b0);
    send_frame(32'h11111111, 10, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    bit_cyc(1'b1, 1'($urandom), 1'b0);
    chk("midrst_dout", dout, '0);
    chk("midrst_locked", DW'(locked), '0);
    rst_n = 1'b1;
    send_frame(32'h76543210, FL, 1'b0, 1'b0, 1'b0);
    chk("postrst_hunt", DW'(locked), '0);
    send_frame(32'h76543210, FL, 1'b1, 1'b0, 1'b0);
    chk("postrst_dout", dout, 32'h76543210);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
